// File: rtl/pad_ctrl_array.sv
// Pad control layer: per-pad config registers, break-before-make config
// handshake, pad output drive, and synchronised/filtered pad input with
// rise/fall event detection.
module pad_ctrl_array #(
  parameter int unsigned N_PADS       = 48,
  parameter int unsigned CFG_W        = 6,
  parameter int unsigned FILT_W       = 4,
  parameter int unsigned GUARD_CYCLES = 2,
  localparam int unsigned IDX_W       = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_req_i,
  input  logic [IDX_W-1:0]           cfg_idx_i,
  input  logic [CFG_W-1:0]           cfg_data_i,
  output logic                       cfg_ack_o,
  output logic [N_PADS*CFG_W-1:0]    pad_cfg_o,
  input  logic [N_PADS-1:0]          core_oe_i,
  input  logic [N_PADS-1:0]          core_out_i,
  output logic [N_PADS-1:0]          core_in_o,
  output logic [N_PADS-1:0]          core_rise_o,
  output logic [N_PADS-1:0]          core_fall_o,
  output logic [N_PADS-1:0]          pad_oen_o,
  output logic [N_PADS-1:0]          pad_i_o,
  output logic [N_PADS-1:0]          pad_pen_o,
  input  logic [N_PADS-1:0]          pad_o_i
);

  localparam int unsigned GC_W       = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int unsigned GUARD_LAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_APPLY
  } state_t;

  state_t                        state_q;
  logic [GC_W-1:0]               guard_cnt_q;
  logic [IDX_W-1:0]              idx_q;
  logic [CFG_W-1:0]              data_q;
  logic [N_PADS-1:0]             guard_mask_q;
  logic [N_PADS-1:0][CFG_W-1:0]  cfg_q;

  logic [N_PADS-1:0]             sync1_q;
  logic [N_PADS-1:0]             sync2_q;
  logic [N_PADS-1:0]             filt_q;
  logic [N_PADS-1:0]             filt_d_q;
  logic [N_PADS-1:0][FILT_W-1:0] filt_cnt_q;

  logic [N_PADS-1:0]             wr_hit;
  logic [N_PADS-1:0][FILT_W-1:0] thr_eff;

  // Config handshake FSM: latch request, hold the pad tristated, then apply.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      guard_cnt_q  <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      guard_mask_q <= '0;
      cfg_ack_o    <= 1'b0;
      cfg_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_req_i) begin
            idx_q       <= cfg_idx_i;
            data_q      <= cfg_data_i;
            guard_cnt_q <= '0;
            for (int n = 0; n < N_PADS; n++) begin
              guard_mask_q[n] <= (cfg_idx_i == IDX_W'(n));
            end
            if (GUARD_CYCLES > 0) begin
              state_q <= S_GUARD;
            end else begin
              state_q   <= S_APPLY;
              cfg_ack_o <= 1'b1;
            end
          end
        end
        S_GUARD: begin
          if (guard_cnt_q == GC_W'(GUARD_LAST)) begin
            state_q   <= S_APPLY;
            cfg_ack_o <= 1'b1;
          end else begin
            guard_cnt_q <= guard_cnt_q + GC_W'(1);
          end
        end
        S_APPLY: begin
          for (int n = 0; n < N_PADS; n++) begin
            if (wr_hit[n]) cfg_q[n] <= data_q;
          end
          guard_mask_q <= '0;
          cfg_ack_o    <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          guard_mask_q <= '0;
          cfg_ack_o    <= 1'b0;
        end
      endcase
    end
  end

  // Per-pad write strobe and effective filter threshold (zero behaves as one).
  always_comb begin
    wr_hit  = '0;
    thr_eff = '0;
    for (int n = 0; n < N_PADS; n++) begin
      wr_hit[n]  = (state_q == S_APPLY) && (idx_q == IDX_W'(n));
      thr_eff[n] = (cfg_q[n][FILT_W+1:2] == '0) ? FILT_W'(1) : cfg_q[n][FILT_W+1:2];
    end
  end

  // Input path: two-flop synchroniser, glitch filter, one-cycle history for edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      filt_d_q   <= '0;
      filt_cnt_q <= '0;
    end else begin
      sync1_q  <= pad_o_i;
      sync2_q  <= sync1_q;
      filt_d_q <= filt_q;
      for (int n = 0; n < N_PADS; n++) begin
        if (!cfg_q[n][1]) begin
          filt_q[n]     <= sync2_q[n];
          filt_cnt_q[n] <= '0;
        end else if (sync2_q[n] == filt_q[n]) begin
          filt_cnt_q[n] <= '0;
        end else if ((filt_cnt_q[n] + FILT_W'(1)) == thr_eff[n]) begin
          filt_q[n]     <= sync2_q[n];
          filt_cnt_q[n] <= '0;
        end else begin
          filt_cnt_q[n] <= filt_cnt_q[n] + FILT_W'(1);
        end
        if (wr_hit[n]) filt_cnt_q[n] <= '0;
      end
    end
  end

  // Pad drive and core-facing outputs; driver held off during reset and guard.
  always_comb begin
    pad_oen_o   = ~core_oe_i | guard_mask_q | {N_PADS{rst_i}};
    pad_i_o     = core_out_i;
    core_in_o   = filt_q;
    core_rise_o = filt_q & ~filt_d_q;
    core_fall_o = ~filt_q & filt_d_q;
    pad_cfg_o   = cfg_q;
    for (int n = 0; n < N_PADS; n++) begin
      pad_pen_o[n] = ~cfg_q[n][0];
    end
  end

endmodule

// File: doc/pad_ctrl_array.md
# pad_ctrl_array

Parametrised pad control layer between the SoC core and an array of N_PADS bidirectional pad cells. Holds the per-pad configuration registers, drives pad output-enable, output data and pull-enable, and returns pad input through a 2-flop synchroniser, a programmable glitch filter and a rise/fall event detector. Configuration updates use a req/ack handshake with break-before-make: the target pad's driver is tristated for GUARD_CYCLES before the new configuration takes effect. The block sits directly above the pad-cell instances, which stay in the pad frame.

## Interface
- N_PADS, 48: number of pad channels (≥1).
- CFG_W, 6: per-pad config width (≥ FILT_W+2).
- FILT_W, 4: glitch-filter threshold/counter width.
- GUARD_CYCLES, 2: tristate guard length on config change (0 allowed).
- clk_i  in  1  single block clock.
- rst_i  in  1  synchronous reset, active-high.
- cfg_req_i  in  1  config write request; held until cfg_ack_o.
- cfg_idx_i  in  $clog2(N_PADS)  target pad index.
- cfg_data_i  in  CFG_W  new config: [0] pull disable, [1] filter enable, [FILT_W+1:2] filter threshold, rest reserved (stored, no effect).
- cfg_ack_o  out  1  one-cycle pulse when config applied.
- pad_cfg_o  out  N_PADS×CFG_W  current config of every pad.
- core_oe_i  in  N_PADS  core output enable, active-high.
- core_out_i  in  N_PADS  core output data.
- core_in_o  out  N_PADS  filtered pad input.
- core_rise_o / core_fall_o  out  N_PADS  one-cycle edge events on core_in_o.
- pad_oen_o  out  N_PADS  pad-cell OEN, active-low.
- pad_i_o  out  N_PADS  pad-cell output data (= core_out_i).
- pad_pen_o  out  N_PADS  pad-cell pull enable (= ~cfg[0]).
- pad_o_i  in  N_PADS  raw pad-cell input.

## Operation
- Config FSM: IDLE, GUARD, APPLY.
  - IDLE: cfg_req_i=1 → latch cfg_idx_i/cfg_data_i; go GUARD (GUARD_CYCLES>0) else APPLY.
  - GUARD: guard counter counts GUARD_CYCLES cycles; pad_oen_o[idx] forced 1; then APPLY.
  - APPLY: cfg[idx] ← latched data, cfg_ack_o=1, guard mask removed, return IDLE. pad_oen_o[idx] forced 1 in APPLY too.
- Request inputs sampled only at acceptance in IDLE; later changes ignored. Requester drops cfg_req_i in the ack cycle; if still high in the cycle after ack, a new transaction starts.
- cfg_idx_i ≥ N_PADS: handshake completes normally, no register written.
- pad_oen_o[n] = ~core_oe_i[n] | guard_mask[n] (combinational in core_oe_i, mask registered).
- Input path per pad: sync1 ← pad_o_i, sync2 ← sync1, filt register drives core_in_o.
  - Filter off: filt ← sync2 every cycle.
  - Filter on, threshold T (T=0 treated as 1): counter clears when sync2==filt; increments on mismatch; when counter+1==T, filt ← sync2, counter ← 0.
- core_rise_o = filt & ~filt_d, core_fall_o = ~filt & filt_d (filt_d = filt delayed one cycle).
- Config change of filter fields takes effect from the cycle after APPLY; counter is cleared on any cfg write to that pad.

## Timing
- Reset values: cfg all 0 (pull on, filter off), FSM IDLE, cfg_ack_o 0, guard_mask 0, sync/filt/filt_d/counters 0, core_in_o 0, edge outputs 0, pad_oen_o 1 for all pads while rst_i=1.
- Config latency: req seen in IDLE at edge 0 → ack high in cycle GUARD_CYCLES+1 after acceptance; new pad_pen_o visible the cycle after ack.
- Input latency (level change first sampled at edge 1): filter off → core_in_o changes after edge 3; filter on, T → after edge 2+T.
- Pulse shorter than T consecutive sync2 cycles never reaches core_in_o.
- Edge event: asserted exactly the first cycle core_in_o holds its new value.
- After reset release, pads idling high produce one core_rise_o; software discards it.
- Reset mid-transaction: FSM to IDLE, no ack, guard mask cleared, cfg not written.

## Test plan
- Reset: rst_i=1 3 cycles, core_oe_i all 1 → pad_oen_o all 1, pad_pen_o all 1, core_in_o 0, cfg_ack_o 0.
- Config write idx=5, data=6'b000011, GUARD_CYCLES=2, core_oe_i[5]=1 → pad_oen_o[5]=1 for 3 cycles, ack pulse cycle 3, pad_pen_o[5]=0 next cycle; other pads unaffected.
- Filter off, pad_o_i[0] 0→1 → core_in_o[0]=1 after 3 edges, core_rise_o[0] 1-cycle pulse.
- Filter on T=4: 3-cycle high glitch → core_in_o stays 0; 6-cycle high → core_in_o rises after edge 6, fall follows same rule.
- Reset asserted during GUARD → no ack, cfg unchanged (0), guard released; out-of-range idx=60 → ack, no write.
- Back-to-back requests with req held through ack → second transaction starts the cycle after ack, both acks seen.
